// File: rtl/bitrev_stream_pkg.sv
// Shared definitions for the bit-reversal accelerator stream adapters.
// Both the transmit and receive adapters take their default sizes from here.
package bitrev_stream_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_DEPTH      = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_FLUSH = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/axis2fifo.sv
// Receive adapter: captures one result frame from the accelerator's AXI-Stream
// output into a local buffer, then replays it in order into a write-FIFO port.
module axis2fifo
    import bitrev_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] m_axis_tdata,
    input  logic                  m_axis_tvalid,
    output logic                  m_axis_tready,
    input  logic                  m_axis_tlast,
    output logic [DATA_WIDTH-1:0] fifo_wdata,
    output logic                  fifo_wvalid,
    input  logic                  fifo_wready,
    output logic                  done,
    output logic                  len_err,
    output logic                  busy
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    state_e                state;
    logic [IDX_W-1:0]      wr_idx;
    logic [IDX_W-1:0]      rd_idx;
    logic [CNT_W-1:0]      cnt;
    logic [DATA_WIDTH-1:0] buffer [DEPTH];

    logic beat;
    logic cnt_next_full;
    logic last_rd;

    assign beat          = m_axis_tready && m_axis_tvalid;
    assign cnt_next_full = (cnt + CNT_W'(1)) == CNT_FULL;
    assign last_rd       = CNT_W'(rd_idx) == (cnt - CNT_W'(1));

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            wr_idx  <= '0;
            rd_idx  <= '0;
            cnt     <= '0;
            len_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    wr_idx <= '0;
                    rd_idx <= '0;
                    cnt    <= '0;
                    if (start) begin
                        len_err <= 1'b0;
                        state   <= ST_RECV;
                    end
                end
                ST_RECV: begin
                    if (beat) begin
                        wr_idx <= wr_idx + IDX_W'(1);
                        cnt    <= cnt + CNT_W'(1);
                        if (m_axis_tlast) begin
                            state <= ST_DRAIN;
                            if (!cnt_next_full) len_err <= 1'b1;
                        end else if (cnt_next_full) begin
                            state   <= ST_FLUSH;
                            len_err <= 1'b1;
                        end
                    end
                end
                // Overlong frame: keep accepting so the accelerator is never stalled mid-frame.
                ST_FLUSH: begin
                    if (beat && m_axis_tlast) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (fifo_wready) begin
                        rd_idx <= rd_idx + IDX_W'(1);
                        if (last_rd) state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: the frame buffer is deliberately not reset; every word is written before it is read.
    always_ff @(posedge clk) begin
        if (state == ST_RECV && m_axis_tvalid) buffer[wr_idx] <= m_axis_tdata;
    end

    // Moore outputs: decoded only from registers, so reset drops them immediately.
    assign m_axis_tready = (state == ST_RECV) || (state == ST_FLUSH);
    assign fifo_wvalid   = (state == ST_DRAIN);
    assign fifo_wdata    = fifo_wvalid ? buffer[rd_idx] : '0;
    assign done          = (state == ST_DONE);
    assign busy          = (state != ST_IDLE);

endmodule

// File: tb/tb_axis2fifo.sv
// Directed self-checking bench for axis2fifo (DATA_WIDTH=32, DEPTH=4).
module tb_axis2fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] m_axis_tdata = '0;
    logic        m_axis_tvalid = 1'b0;
    logic        m_axis_tready;
    logic        m_axis_tlast = 1'b0;
    logic [31:0] fifo_wdata;
    logic        fifo_wvalid;
    logic        fifo_wready = 1'b0;
    logic        done;
    logic        len_err;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    int          cyc = 0;
    logic [31:0] wq[$];
    int          wc[$];
    int          done_cnt = 0;
    int          done_cyc = 0;

    axis2fifo #(.DATA_WIDTH(32), .DEPTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .fifo_wdata    (fifo_wdata),
        .fifo_wvalid   (fifo_wvalid),
        .fifo_wready   (fifo_wready),
        .done          (done),
        .len_err       (len_err),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Record FIFO writes and done pulses as seen at each rising edge.
    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            if (fifo_wvalid && fifo_wready) begin
                wq.push_back(fifo_wdata);
                wc.push_back(cyc);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arm();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic l);
        int k = 0;
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = d;
        m_axis_tlast  = l;
        while (!m_axis_tready && k < 50) begin
            tick();
            k++;
        end
        n_cmp++;
        if (k >= 50) begin
            n_err++;
            $display("FAIL beat_timeout: tready=%b after %0d cycles, need 1", m_axis_tready, k);
        end
        tick();
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tdata  = 32'hDEAD_BEEF;
    endtask

    task automatic wait_done(input int d0);
        int k = 0;
        while (done_cnt == d0 && k < 60) begin
            tick();
            k++;
        end
        n_cmp++;
        if (done_cnt != d0 + 1) begin
            n_err++;
            $display("FAIL done_count: got %0d pulses, need %0d", done_cnt - d0, 1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_cmp += 6;
        if (m_axis_tready !== 1'b0) begin n_err++; $display("FAIL rst_tready: got %b need 0", m_axis_tready); end
        if (fifo_wvalid !== 1'b0)   begin n_err++; $display("FAIL rst_wvalid: got %b need 0", fifo_wvalid); end
        if (fifo_wdata !== 32'h0)   begin n_err++; $display("FAIL rst_wdata: got %h need 0", fifo_wdata); end
        if (done !== 1'b0)          begin n_err++; $display("FAIL rst_done: got %b need 0", done); end
        if (len_err !== 1'b0)       begin n_err++; $display("FAIL rst_len_err: got %b need 0", len_err); end
        if (busy !== 1'b0)          begin n_err++; $display("FAIL rst_busy: got %b need 0", busy); end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (m_axis_tready !== 1'b0) begin n_err++; $display("FAIL idle_tready: got %b need 0", m_axis_tready); end
    endtask

    task automatic test_normal();
        logic [31:0] exp [4];
        logic [31:0] got;
        int d0;
        exp = '{32'h11, 32'h22, 32'h33, 32'h44};
        wq.delete();
        wc.delete();
        d0 = done_cnt;
        fifo_wready = 1'b1;
        arm();
        n_cmp += 2;
        if (m_axis_tready !== 1'b1) begin n_err++; $display("FAIL arm_tready: got %b need 1", m_axis_tready); end
        if (busy !== 1'b1)          begin n_err++; $display("FAIL arm_busy: got %b need 1", busy); end
        for (int i = 0; i < 4; i++) send_beat(exp[i], i == 3);
        n_cmp += 3;
        if (fifo_wvalid !== 1'b1)   begin n_err++; $display("FAIL drain_wvalid: got %b need 1", fifo_wvalid); end
        if (fifo_wdata !== 32'h11)  begin n_err++; $display("FAIL drain_first: got %h need 11", fifo_wdata); end
        if (m_axis_tready !== 1'b0) begin n_err++; $display("FAIL drain_tready: got %b need 0", m_axis_tready); end
        wait_done(d0);
        n_cmp++;
        if (wq.size() != 4) begin n_err++; $display("FAIL normal_count: got %0d writes need 4", wq.size()); end
        for (int i = 0; i < 4; i++) begin
            got = (i < wq.size()) ? wq[i] : 32'hx;
            n_cmp++;
            if (got !== exp[i]) begin n_err++; $display("FAIL normal_word%0d: got %h need %h", i, got, exp[i]); end
        end
        if (wc.size() == 4) begin
            for (int i = 1; i < 4; i++) begin
                n_cmp++;
                if (wc[i] != wc[0] + i) begin n_err++; $display("FAIL normal_rate%0d: got cycle %0d need %0d", i, wc[i], wc[0] + i); end
            end
            n_cmp++;
            if (done_cyc != wc[3] + 1) begin n_err++; $display("FAIL done_timing: got cycle %0d need %0d", done_cyc, wc[3] + 1); end
        end
        n_cmp += 3;
        if (len_err !== 1'b0)      begin n_err++; $display("FAIL normal_len_err: got %b need 0", len_err); end
        if (busy !== 1'b0)         begin n_err++; $display("FAIL normal_busy_end: got %b need 0", busy); end
        if (fifo_wdata !== 32'h0)  begin n_err++; $display("FAIL idle_wdata: got %h need 0", fifo_wdata); end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp [4];
        logic [31:0] got;
        logic        pat [4];
        logic        prev_stall;
        logic [31:0] prev_data;
        int d0;
        exp = '{32'h11, 32'h22, 32'h33, 32'h44};
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        wq.delete();
        d0 = done_cnt;
        fifo_wready = 1'b0;
        arm();
        for (int i = 0; i < 4; i++) send_beat(exp[i], i == 3);
        prev_stall = 1'b0;
        prev_data  = '0;
        for (int i = 0; i < 40 && done_cnt == d0; i++) begin
            fifo_wready = pat[i % 4];
            if (prev_stall && fifo_wvalid) begin
                n_cmp++;
                if (fifo_wdata !== prev_data) begin n_err++; $display("FAIL stall_hold: got %h need %h", fifo_wdata, prev_data); end
            end
            prev_stall = fifo_wvalid && !fifo_wready;
            prev_data  = fifo_wdata;
            tick();
        end
        fifo_wready = 1'b1;
        n_cmp += 2;
        if (done_cnt != d0 + 1) begin n_err++; $display("FAIL bp_done: got %0d pulses need 1", done_cnt - d0); end
        if (wq.size() != 4)     begin n_err++; $display("FAIL bp_count: got %0d writes need 4", wq.size()); end
        for (int i = 0; i < 4; i++) begin
            got = (i < wq.size()) ? wq[i] : 32'hx;
            n_cmp++;
            if (got !== exp[i]) begin n_err++; $display("FAIL bp_word%0d: got %h need %h", i, got, exp[i]); end
        end
    endtask

    task automatic test_short();
        logic [31:0] got;
        int d0;
        wq.delete();
        d0 = done_cnt;
        fifo_wready = 1'b1;
        arm();
        send_beat(32'hA0, 1'b0);
        send_beat(32'hA1, 1'b1);
        wait_done(d0);
        n_cmp += 2;
        if (wq.size() != 2)   begin n_err++; $display("FAIL short_count: got %0d writes need 2", wq.size()); end
        if (len_err !== 1'b1) begin n_err++; $display("FAIL short_len_err: got %b need 1", len_err); end
        got = (wq.size() > 0) ? wq[0] : 32'hx;
        n_cmp++;
        if (got !== 32'hA0) begin n_err++; $display("FAIL short_word0: got %h need a0", got); end
        got = (wq.size() > 1) ? wq[1] : 32'hx;
        n_cmp++;
        if (got !== 32'hA1) begin n_err++; $display("FAIL short_word1: got %h need a1", got); end
        tick();
        tick();
        n_cmp++;
        if (len_err !== 1'b1) begin n_err++; $display("FAIL short_sticky: got %b need 1", len_err); end
    endtask

    task automatic test_overrun();
        logic [31:0] got;
        int d0;
        wq.delete();
        d0 = done_cnt;
        fifo_wready = 1'b1;
        arm();
        n_cmp++;
        if (len_err !== 1'b0) begin n_err++; $display("FAIL start_clears_len_err: got %b need 0", len_err); end
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (m_axis_tready !== 1'b1) begin n_err++; $display("FAIL over_tready%0d: got %b need 1", i, m_axis_tready); end
            send_beat(32'hB0 + 32'(i), i == 5);
        end
        wait_done(d0);
        n_cmp += 2;
        if (wq.size() != 4)   begin n_err++; $display("FAIL over_count: got %0d writes need 4", wq.size()); end
        if (len_err !== 1'b1) begin n_err++; $display("FAIL over_len_err: got %b need 1", len_err); end
        for (int i = 0; i < 4; i++) begin
            got = (i < wq.size()) ? wq[i] : 32'hx;
            n_cmp++;
            if (got !== 32'hB0 + 32'(i)) begin n_err++; $display("FAIL over_word%0d: got %h need %h", i, got, 32'hB0 + 32'(i)); end
        end
    endtask

    task automatic test_stalls();
        logic [31:0] got;
        int d0;
        wq.delete();
        d0 = done_cnt;
        fifo_wready = 1'b0;
        arm();
        for (int i = 0; i < 4; i++) begin
            send_beat(32'hD0 + 32'(i), i == 3);
            tick();
            tick();
        end
        // Frame is now waiting in drain; a start pulse here must be ignored.
        n_cmp++;
        if (fifo_wvalid !== 1'b1) begin n_err++; $display("FAIL stall_drain_wait: got %b need 1", fifo_wvalid); end
        start = 1'b1;
        tick();
        start = 1'b0;
        fifo_wready = 1'b1;
        wait_done(d0);
        n_cmp++;
        if (wq.size() != 4) begin n_err++; $display("FAIL stall_count: got %0d writes need 4", wq.size()); end
        for (int i = 0; i < 4; i++) begin
            got = (i < wq.size()) ? wq[i] : 32'hx;
            n_cmp++;
            if (got !== 32'hD0 + 32'(i)) begin n_err++; $display("FAIL stall_word%0d: got %h need %h", i, got, 32'hD0 + 32'(i)); end
        end
        for (int i = 0; i < 8; i++) tick();
        n_cmp += 3;
        if (busy !== 1'b0)          begin n_err++; $display("FAIL ignored_start_busy: got %b need 0", busy); end
        if (m_axis_tready !== 1'b0) begin n_err++; $display("FAIL ignored_start_tready: got %b need 0", m_axis_tready); end
        if (done_cnt != d0 + 1)     begin n_err++; $display("FAIL ignored_start_done: got %0d pulses need 1", done_cnt - d0); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] got;
        int d0;
        wq.delete();
        d0 = done_cnt;
        fifo_wready = 1'b1;
        arm();
        send_beat(32'hE0, 1'b0);
        send_beat(32'hE1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        n_cmp += 5;
        if (m_axis_tready !== 1'b0) begin n_err++; $display("FAIL mid_rst_tready: got %b need 0", m_axis_tready); end
        if (fifo_wvalid !== 1'b0)   begin n_err++; $display("FAIL mid_rst_wvalid: got %b need 0", fifo_wvalid); end
        if (fifo_wdata !== 32'h0)   begin n_err++; $display("FAIL mid_rst_wdata: got %h need 0", fifo_wdata); end
        if (done !== 1'b0)          begin n_err++; $display("FAIL mid_rst_done: got %b need 0", done); end
        if (busy !== 1'b0)          begin n_err++; $display("FAIL mid_rst_busy: got %b need 0", busy); end
        tick();
        tick();
        rst = 1'b0;
        tick();
        n_cmp += 2;
        if (done_cnt != d0) begin n_err++; $display("FAIL mid_rst_no_done: got %0d pulses need 0", done_cnt - d0); end
        if (wq.size() != 0) begin n_err++; $display("FAIL mid_rst_no_write: got %0d writes need 0", wq.size()); end
        arm();
        for (int i = 0; i < 4; i++) send_beat(32'hF0 + 32'(i), i == 3);
        wait_done(d0);
        n_cmp += 2;
        if (wq.size() != 4)   begin n_err++; $display("FAIL post_rst_count: got %0d writes need 4", wq.size()); end
        if (len_err !== 1'b0) begin n_err++; $display("FAIL post_rst_len_err: got %b need 0", len_err); end
        for (int i = 0; i < 4; i++) begin
            got = (i < wq.size()) ? wq[i] : 32'hx;
            n_cmp++;
            if (got !== 32'hF0 + 32'(i)) begin n_err++; $display("FAIL post_rst_word%0d: got %h need %h", i, got, 32'hF0 + 32'(i)); end
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_backpressure();
        test_short();
        test_overrun();
        test_stalls();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axis2fifo.md
# axis2fifo

Receive-side adapter for the bit-reversal accelerator. Acts as an AXI-Stream slave on the accelerator's result stream, collects one frame of up to DEPTH words into a local buffer, then drains the frame in order into a downstream write-FIFO interface facing the bus side. It pairs with the transmit adapter that feeds operands into the accelerator. It reports frame completion and frame-length errors.

## Interface
- DATA_WIDTH, 32, width of stream and FIFO words
- DEPTH, 4, frame length in words; power of two, ≥2
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  arms reception of one frame; sampled only in IDLE
- m_axis_tdata  in  DATA_WIDTH  result stream data from accelerator
- m_axis_tvalid  in  1  result stream valid
- m_axis_tready  out  1  result stream ready
- m_axis_tlast  in  1  last beat of result frame
- fifo_wdata  out  DATA_WIDTH  word to downstream FIFO; 0 when fifo_wvalid=0
- fifo_wvalid  out  1  word available
- fifo_wready  in  1  downstream FIFO accepts word
- done  out  1  one-cycle pulse, frame fully drained
- len_err  out  1  sticky; frame length ≠ DEPTH; cleared when start is accepted
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, RECV, FLUSH, DRAIN, DONE.
- IDLE:
  - On start → RECV.
  - Clear wr_idx, rd_idx, cnt, len_err.
- RECV:
  - m_axis_tready=1.
  - A beat is accepted when tvalid&&tready.
  - Each beat stores to buffer[wr_idx], increments wr_idx and cnt.
  - Accepted beat with tlast and cnt+1==DEPTH → DRAIN (normal).
  - Accepted beat with tlast and cnt+1<DEPTH → DRAIN, set len_err (short frame; drain cnt+1 words).
  - Accepted beat without tlast and cnt+1==DEPTH → FLUSH, set len_err.
- FLUSH:
  - m_axis_tready=1.
  - Accepted beats are discarded.
  - Accepted beat with tlast → DRAIN (DEPTH words drained).
- DRAIN:
  - fifo_wvalid=1, fifo_wdata=buffer[rd_idx].
  - On fifo_wready, rd_idx increments.
  - The handshake on word cnt-1 → DONE.
  - wvalid stays high and data stays stable until fifo_wready.
- DONE:
  - done=1 for exactly one cycle → IDLE.
- m_axis_tready=0 in IDLE, DRAIN and DONE. Back-pressure on the accelerator is the only flow control; no beat is ever dropped in RECV.
- start outside IDLE is ignored.
- cnt width: $clog2(DEPTH+1). wr_idx and rd_idx width: $clog2(DEPTH). Indices never wrap within a frame.
- X on m_axis_tdata is stored as-is. No data-value qualification is performed.

## Timing
- All outputs are Moore, decoded from registered state, indices and buffer. There are no combinational paths from inputs to outputs.
- Reset values: m_axis_tready=0, fifo_wvalid=0, fifo_wdata=0, done=0, len_err=0, busy=0, state=IDLE. Buffer contents are not reset.
- start high at edge k → tready=1 from cycle k+1.
- Last beat accepted at edge n → fifo_wvalid=1 from cycle n+1.
- Full-rate drain: DEPTH words in DEPTH cycles when fifo_wready is held high.
- Final drain handshake at edge m → done=1 during cycle m+1 → busy=0 and IDLE in cycle m+2.
- Minimum frame turnaround with both sides always ready: 1 (arm) + DEPTH + DEPTH + 1 cycles.
- Reset asserted mid-operation:
  - Immediate return to IDLE.
  - tready and wvalid drop asynchronously.
  - The partial frame is lost; no done pulse is generated.

## Structure
- Shared package bitrev_stream_pkg holds:
  - state enum (IDLE, RECV, FLUSH, DRAIN, DONE), 3 bits;
  - default DATA_WIDTH and DEPTH constants, shared with the transmit adapter.
- Single module. The buffer is an inline register array; no sub-module is warranted.

## Test plan
- Normal frame:
  - Stimulus: start, then beats 0x11,0x22,0x33,0x44 with tlast on 0x44, fifo_wready=1.
  - Response: fifo writes 0x11..0x44 in order on 4 consecutive cycles, done one cycle later, len_err=0.
- Drain back-pressure:
  - Stimulus: same frame, fifo_wready toggling 1,0,0,1,…
  - Response: wdata holds through stalls, exactly 4 writes, order preserved.
- Short frame:
  - Stimulus: 0xA0,0xA1 with tlast on 0xA1.
  - Response: 2 writes, done, len_err=1; len_err clears on the next accepted start.
- Overrun:
  - Stimulus: 6 beats 0xB0..0xB5, tlast on 0xB5.
  - Response: tready stays 1 through 0xB5, writes are 0xB0..0xB3 only, len_err=1.
- Input stalls:
  - Stimulus: tvalid gaps between beats, and start pulsed during DRAIN.
  - Response: no extra beats captured; start is ignored, so there is no second frame without a new start in IDLE.
- Reset mid-frame:
  - Stimulus: rst after 2 beats.
  - Response: all outputs at reset values on the same cycle; no done pulse; the next frame is received cleanly.
